// File: rtl/sync_fifo_thresh.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_thresh
//  Description : Single-clock FIFO with selectable standard / first-word-
//                fall-through read mode, programmable almost-full and
//                almost-empty flags, an occupancy count and sticky
//                overflow / underflow error flags.
//  Ports       : clk, rst (async, active-high)
//                i_data, w_en            write side
//                r_en                    read request / FWFT pop
//                clr_err                 clears overflow / underflow
//                o_data, o_valid         read data and its qualifier
//                full, empty, almost_full, almost_empty, count
//                overflow, underflow     sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_thresh #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 10,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_depth   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth_v = (ADDR_WIDTH + 1)'(c_depth);
    localparam logic [ADDR_WIDTH:0] c_af      = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] c_ae      = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] c_cnt_one = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    // Threshold ordering is a build-time property; refuse to elaborate otherwise.
    if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= c_depth))) begin : g_param_err
        $error("sync_fifo_thresh: need 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_o_data;
    logic                  r_o_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr;        // write accepted
    logic w_rd;        // read accepted (word leaves the FIFO's count)
    logic w_mem_pop;   // word leaves the storage array

    assign w_full = (r_count == c_depth_v);
    assign w_wr   = w_en && !w_full;

    if (FWFT != 0) begin : g_fwft
        // Storage holds everything except the word already parked on o_data.
        logic [ADDR_WIDTH:0] w_mem_count;
        assign w_mem_count = r_count - {{ADDR_WIDTH{1'b0}}, r_o_valid};
        assign w_rd        = r_en && r_o_valid;
        // Refill the output register whenever it is free or being popped.
        assign w_mem_pop   = (w_mem_count != '0) && (!r_o_valid || w_rd);
        assign w_empty     = !r_o_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_o_data  <= '0;
                r_o_valid <= 1'b0;
            end else if (w_mem_pop) begin
                r_o_data  <= r_mem[r_rptr];
                r_o_valid <= 1'b1;
            end else if (w_rd) begin
                r_o_valid <= 1'b0;
            end
        end
    end else begin : g_std
        assign w_rd      = r_en && (r_count != '0);
        assign w_mem_pop = w_rd;
        assign w_empty   = (r_count == '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_o_data  <= '0;
                r_o_valid <= 1'b0;
            end else begin
                r_o_valid <= w_rd;
                if (w_rd) begin
                    r_o_data <= r_mem[r_rptr];
                end
            end
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_mem_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - c_cnt_one;
            end
            // A fresh error in the clearing cycle takes priority over the clear.
            if (w_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (r_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_data       = r_o_data;
    assign o_valid      = r_o_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af);
    assign almost_empty = (r_count <= c_ae);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_thresh.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_thresh
//  Description : Directed bench for sync_fifo_thresh. Two 8-deep instances
//                (standard and FWFT) with AF_THRESH=4, AE_THRESH=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_thresh;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] i_data;
    logic       clr_err;
    logic       w_en_s, r_en_s, w_en_f, r_en_f;

    logic [8:0] o_data_s, o_data_f;
    logic       o_valid_s, o_valid_f, full_s, full_f, empty_s, empty_f;
    logic       af_s, af_f, ae_s, ae_f, ovf_s, ovf_f, unf_s, unf_f;
    logic [3:0] count_s, count_f;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_thresh #(
        .DATA_WIDTH(9), .ADDR_WIDTH(3), .FWFT(0), .AF_THRESH(4), .AE_THRESH(3)
    ) u_std (
        .clk(clk), .rst(rst), .i_data(i_data), .w_en(w_en_s), .r_en(r_en_s),
        .clr_err(clr_err), .o_data(o_data_s), .o_valid(o_valid_s),
        .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
        .count(count_s), .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_thresh #(
        .DATA_WIDTH(9), .ADDR_WIDTH(3), .FWFT(1), .AF_THRESH(4), .AE_THRESH(3)
    ) u_fwft (
        .clk(clk), .rst(rst), .i_data(i_data), .w_en(w_en_f), .r_en(r_en_f),
        .clr_err(clr_err), .o_data(o_data_f), .o_valid(o_valid_f),
        .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
        .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; i_data = '0; clr_err = 1'b0;
        w_en_s = 1'b0; r_en_s = 1'b0; w_en_f = 1'b0; r_en_f = 1'b0;
        step(); step();

        // ---------------- reset state ----------------
        check("rst_count",   32'(count_s),   32'd0);
        check("rst_empty",   32'(empty_s),   32'd1);
        check("rst_full",    32'(full_s),    32'd0);
        check("rst_ae",      32'(ae_s),      32'd1);
        check("rst_af",      32'(af_s),      32'd0);
        check("rst_odata",   32'(o_data_s),  32'd0);
        check("rst_ovalid",  32'(o_valid_s), 32'd0);
        check("rst_ovf",     32'(ovf_s),     32'd0);
        check("rst_unf",     32'(unf_s),     32'd0);
        check("rst_f_valid", 32'(o_valid_f), 32'd0);
        check("rst_f_empty", 32'(empty_f),   32'd1);
        rst = 1'b0;
        step();

        // ---------------- fill ----------------
        w_en_s = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_data = 9'(i);
            step();
            check("fill_count", 32'(count_s), 32'(i + 1));
            check("fill_af",    32'(af_s),    32'((i + 1) >= 4));
            check("fill_ae",    32'(ae_s),    32'((i + 1) <= 3));
            check("fill_full",  32'(full_s),  32'((i + 1) == 8));
        end
        i_data = 9'h1FF;
        step();
        check("ovf_set",   32'(ovf_s),   32'd1);
        check("ovf_count", 32'(count_s), 32'd8);
        w_en_s = 1'b0;

        // ---------------- drain ----------------
        r_en_s = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("drain_data",  32'(o_data_s),  32'(k));
            check("drain_valid", 32'(o_valid_s), 32'd1);
            check("drain_count", 32'(count_s),   32'(7 - k));
            check("drain_ae",    32'(ae_s),      32'((7 - k) <= 3));
            check("drain_empty", 32'(empty_s),   32'(k == 7));
        end
        step();
        check("unf_set",   32'(unf_s),     32'd1);
        check("unf_valid", 32'(o_valid_s), 32'd0);
        check("unf_hold",  32'(o_data_s),  32'd7);
        r_en_s = 1'b0;

        clr_err = 1'b1;
        step();
        check("clr_ovf", 32'(ovf_s), 32'd0);
        check("clr_unf", 32'(unf_s), 32'd0);
        clr_err = 1'b0;

        // ---------------- simultaneous read/write ----------------
        w_en_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_data = 9'h010 + 9'(i);
            step();
        end
        check("sim_pre_count", 32'(count_s), 32'd5);
        r_en_s = 1'b1;
        for (int j = 0; j < 10; j++) begin
            i_data = 9'h020 + 9'(j);
            step();
            check("sim_count", 32'(count_s), 32'd5);
            check("sim_data",  32'(o_data_s), (j < 5) ? 32'(9'h010 + 9'(j)) : 32'(9'h020 + 9'(j - 5)));
        end
        r_en_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_data = 9'h030 + 9'(i);
            step();
        end
        check("sim_full", 32'(full_s), 32'd1);
        i_data = 9'h1FF;
        step();
        check("full_wr_ovf", 32'(ovf_s), 32'd1);
        r_en_s = 1'b1; clr_err = 1'b1; i_data = 9'h1EE;
        step();
        check("full_rw_count", 32'(count_s),  32'd7);
        check("full_rw_data",  32'(o_data_s), 32'h025);
        check("clr_vs_err",    32'(ovf_s),    32'd1);
        w_en_s = 1'b0; r_en_s = 1'b0;
        step();
        check("clr_ovf2", 32'(ovf_s),   32'd0);
        check("hold_cnt", 32'(count_s), 32'd7);
        clr_err = 1'b0;

        r_en_s = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            check("drain2_data", 32'(o_data_s), (k < 4) ? 32'(9'h026 + 9'(k)) : 32'(9'h030 + 9'(k - 4)));
        end
        check("drain2_count", 32'(count_s), 32'd0);
        r_en_s = 1'b0;

        // ---------------- wrap with 3-deep backlog ----------------
        w_en_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 9'h040 + 9'(i);
            step();
        end
        r_en_s = 1'b1;
        for (int j = 0; j < 20; j++) begin
            i_data = 9'h043 + 9'(j);
            step();
            check("wrap_data",  32'(o_data_s), 32'(9'h040 + 9'(j)));
            check("wrap_count", 32'(count_s),  32'd3);
        end
        w_en_s = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("wrap_tail", 32'(o_data_s), 32'(9'h054 + 9'(j)));
        end
        step();
        check("wrap_unf", 32'(unf_s), 32'd1);
        r_en_s = 1'b0;

        // ---------------- reset mid-stream ----------------
        w_en_s = 1'b1;
        for (int i = 0; i < 7; i++) begin
            i_data = 9'h060 + 9'(i);
            step();
        end
        w_en_s = 1'b0;
        check("mid_count", 32'(count_s), 32'd7);
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count_s),   32'd0);
        check("arst_empty", 32'(empty_s),   32'd1);
        check("arst_valid", 32'(o_valid_s), 32'd0);
        check("arst_unf",   32'(unf_s),     32'd0);
        check("arst_ae",    32'(ae_s),      32'd1);
        check("arst_odata", 32'(o_data_s),  32'd0);
        step();
        rst = 1'b0;
        w_en_s = 1'b1; i_data = 9'h1A5;
        step();
        w_en_s = 1'b0;
        check("post_count", 32'(count_s), 32'd1);
        r_en_s = 1'b1;
        step();
        r_en_s = 1'b0;
        check("post_data",  32'(o_data_s),  32'h1A5);
        check("post_valid", 32'(o_valid_s), 32'd1);

        // ---------------- FWFT ----------------
        w_en_f = 1'b1; i_data = 9'h055;
        step();
        check("fw_k_valid", 32'(o_valid_f), 32'd0);
        check("fw_k_count", 32'(count_f),   32'd1);
        i_data = 9'h066;
        step();
        w_en_f = 1'b0;
        check("fw_k1_valid", 32'(o_valid_f), 32'd1);
        check("fw_k1_data",  32'(o_data_f),  32'h055);
        check("fw_k1_empty", 32'(empty_f),   32'd0);
        check("fw_k1_count", 32'(count_f),   32'd2);
        r_en_f = 1'b1;
        step();
        check("fw_pop_data",  32'(o_data_f),  32'h066);
        check("fw_pop_valid", 32'(o_valid_f), 32'd1);
        check("fw_pop_count", 32'(count_f),   32'd1);
        step();
        check("fw_last_valid", 32'(o_valid_f), 32'd0);
        check("fw_last_empty", 32'(empty_f),   32'd1);
        check("fw_last_count", 32'(count_f),   32'd0);
        step();
        check("fw_unf", 32'(unf_f), 32'd1);
        r_en_f = 1'b0;

        w_en_f = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_data = 9'h070 + 9'(i);
            step();
        end
        w_en_f = 1'b0;
        check("fw_full",      32'(full_f),   32'd1);
        check("fw_full_cnt",  32'(count_f),  32'd8);
        check("fw_full_head", 32'(o_data_f), 32'h070);
        r_en_f = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 7) check("fw_drain_data", 32'(o_data_f), 32'(9'h071 + 9'(i)));
            check("fw_drain_count", 32'(count_f), 32'(7 - i));
        end
        check("fw_drain_empty", 32'(empty_f), 32'd1);
        r_en_f = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
